// File: rtl/bg_write_arbiter_4x4.sv
// bg_write_arbiter_4x4
//
// Write-side front end for the bank-group LSU crossbar. Each of the four
// LSUs pushes write requests into its own small FIFO. Every cycle the FIFO
// heads are arbitrated per bank group (BG) with an independent round-robin
// pointer per BG. A BG that carries a read in the same cycle (bg_ren[k]) gets
// no write grant. Output slot k carries only the write granted to BG k, and
// its sel field is tied to k. Because of this, the crossbar's fixed-priority
// select never drops a write, and a write never shares a BG bus with a read.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   lsu_w_valid[4]    per-LSU write valid
//   lsu_w_ready[4]    per-LSU accept (combinational, FIFO not full)
//   lsu_w_sel[8]      target BG per LSU, [2i+1:2i]
//   lsu_w_addr        per-LSU address, LSU0 at LSB
//   lsu_w_data        per-LSU data, LSU0 at LSB
//   bg_ren[4]         same-cycle read enable per BG
//   W_request_0..3    {sel=k, Wen, addr, data} per crossbar write slot
//   bg_grant_lsu[8]   last granted LSU per BG (holds when idle)
//   arb_conflict      registered: head collision or read-blocked head
//
// Optional build macro BG_WARB_PERF_CNT_EN adds perf_blk_cnt (4x16,
// LSU0 at LSB). Each field is a saturating count of the cycles in which that
// LSU's non-empty head was not granted.

module bg_write_arbiter_4x4 #(
    parameter int A_W        = 10,
    parameter int D_W        = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            lsu_w_valid,
    output logic [3:0]            lsu_w_ready,
    input  logic [7:0]            lsu_w_sel,
    input  logic [4*A_W-1:0]      lsu_w_addr,
    input  logic [4*D_W-1:0]      lsu_w_data,
    input  logic [3:0]            bg_ren,
    output logic [3+A_W+D_W-1:0]  W_request_0,
    output logic [3+A_W+D_W-1:0]  W_request_1,
    output logic [3+A_W+D_W-1:0]  W_request_2,
    output logic [3+A_W+D_W-1:0]  W_request_3,
    output logic [7:0]            bg_grant_lsu,
`ifdef BG_WARB_PERF_CNT_EN
    output logic                  arb_conflict,
    output logic [63:0]           perf_blk_cnt
`else
    output logic                  arb_conflict
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // FIFO storage and pointers
    logic [1:0]       fifo_sel  [4][FIFO_DEPTH];
    logic [A_W-1:0]   fifo_addr [4][FIFO_DEPTH];
    logic [D_W-1:0]   fifo_data [4][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [4];
    logic [PTR_W-1:0] rd_ptr [4];
    logic [CNT_W-1:0] count  [4];

    logic [3:0]       push;
    logic [3:0]       pop;
    logic [3:0]       not_empty;
    logic [1:0]       head_sel  [4];
    logic [A_W-1:0]   head_addr [4];
    logic [D_W-1:0]   head_data [4];

    // Arbitration
    logic [1:0]       rr_ptr    [4];
    logic [3:0]       grant_vld;
    logic [1:0]       grant_idx [4];
    logic [2:0]       ncand     [4];
    logic [1:0]       scan_idx;
    logic             conflict_d;

    // Output registers
    logic [3:0]       wen_q;
    logic [A_W-1:0]   addr_q [4];
    logic [D_W-1:0]   data_q [4];
    logic [7:0]       grant_q;
    logic             conflict_q;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            // Readiness depends only on the current occupancy. A full FIFO
            // stays not-ready even in a cycle where it pops.
            lsu_w_ready[i] = (count[i] < DEPTH_C);
            push[i]        = lsu_w_valid[i] & lsu_w_ready[i];
            not_empty[i]   = (count[i] != '0);
            head_sel[i]    = fifo_sel[i][rd_ptr[i]];
            head_addr[i]   = fifo_addr[i][rd_ptr[i]];
            head_data[i]   = fifo_data[i][rd_ptr[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (push[i]) begin
                fifo_sel[i][wr_ptr[i]]  <= lsu_w_sel[2*i +: 2];
                fifo_addr[i][wr_ptr[i]] <= lsu_w_addr[A_W*i +: A_W];
                fifo_data[i][wr_ptr[i]] <= lsu_w_data[D_W*i +: D_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i])
                    count[i] <= count[i] + CNT_W'(1);
                else if (pop[i] && !push[i])
                    count[i] <= count[i] - CNT_W'(1);
            end
        end
    end

    // Per-BG round-robin over the FIFO heads. Each LSU exposes exactly one
    // head with one target BG, so at most one BG can grant a given LSU, and
    // the pop vector never receives two grants for the same FIFO.
    always_comb begin
        grant_vld  = '0;
        pop        = '0;
        conflict_d = 1'b0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            grant_idx[k] = '0;
            ncand[k]     = '0;
        end
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (not_empty[i] && head_sel[i] == 2'(k))
                    ncand[k] = ncand[k] + 3'd1;
            end
            if (ncand[k] >= 3'd2 || (bg_ren[k] && ncand[k] != '0))
                conflict_d = 1'b1;
            if (!bg_ren[k]) begin
                for (int unsigned off = 0; off < 4; off++) begin
                    scan_idx = rr_ptr[k] + 2'(off);
                    if (!grant_vld[k] && not_empty[scan_idx] &&
                        head_sel[scan_idx] == 2'(k)) begin
                        grant_vld[k] = 1'b1;
                        grant_idx[k] = scan_idx;
                    end
                end
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            if (grant_vld[k]) pop[grant_idx[k]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q      <= '0;
            grant_q    <= '0;
            conflict_q <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
                rr_ptr[k] <= '0;
            end
        end else begin
            conflict_q <= conflict_d;
            for (int unsigned k = 0; k < 4; k++) begin
                wen_q[k] <= grant_vld[k];
                if (grant_vld[k]) begin
                    addr_q[k]          <= head_addr[grant_idx[k]];
                    data_q[k]          <= head_data[grant_idx[k]];
                    grant_q[2*k +: 2]  <= grant_idx[k];
                    rr_ptr[k]          <= grant_idx[k] + 2'd1;
                end else begin
                    addr_q[k] <= '0;
                    data_q[k] <= '0;
                end
            end
        end
    end

    assign W_request_0  = {2'd0, wen_q[0], addr_q[0], data_q[0]};
    assign W_request_1  = {2'd1, wen_q[1], addr_q[1], data_q[1]};
    assign W_request_2  = {2'd2, wen_q[2], addr_q[2], data_q[2]};
    assign W_request_3  = {2'd3, wen_q[3], addr_q[3], data_q[3]};
    assign bg_grant_lsu = grant_q;
    assign arb_conflict = conflict_q;

`ifdef BG_WARB_PERF_CNT_EN
    logic [15:0] blk_cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) blk_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (not_empty[i] && !pop[i] && blk_cnt[i] != '1)
                    blk_cnt[i] <= blk_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        perf_blk_cnt = '0;
        for (int unsigned i = 0; i < 4; i++) perf_blk_cnt[16*i +: 16] = blk_cnt[i];
    end
`endif

endmodule

// File: tb/tb_bg_write_arbiter_4x4.sv
// Self-checking bench for bg_write_arbiter_4x4. The reference model keeps
// each LSU FIFO as a plain array of entries and applies the round-robin rule
// per bank group. Directed scenarios run first, followed by a randomized run.
module tb_bg_write_arbiter_4x4;
    localparam int A_W   = 10;
    localparam int D_W   = 32;
    localparam int DEPTH = 2;
    localparam int WR_W  = 3 + A_W + D_W;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           lsu_w_valid = '0;
    logic [3:0]           lsu_w_ready;
    logic [7:0]           lsu_w_sel = '0;
    logic [4*A_W-1:0]     lsu_w_addr = '0;
    logic [4*D_W-1:0]     lsu_w_data = '0;
    logic [3:0]           bg_ren = '0;
    logic [WR_W-1:0]      W_request_0, W_request_1, W_request_2, W_request_3;
    logic [7:0]           bg_grant_lsu;
    logic                 arb_conflict;
`ifdef BG_WARB_PERF_CNT_EN
    logic [63:0]          perf_blk_cnt;
`endif

    bg_write_arbiter_4x4 #(.A_W(A_W), .D_W(D_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready),
        .lsu_w_sel(lsu_w_sel), .lsu_w_addr(lsu_w_addr), .lsu_w_data(lsu_w_data),
        .bg_ren(bg_ren),
        .W_request_0(W_request_0), .W_request_1(W_request_1),
        .W_request_2(W_request_2), .W_request_3(W_request_3),
        .bg_grant_lsu(bg_grant_lsu),
`ifdef BG_WARB_PERF_CNT_EN
        .arb_conflict(arb_conflict),
        .perf_blk_cnt(perf_blk_cnt)
`else
        .arb_conflict(arb_conflict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]     sel;
        logic [A_W-1:0] addr;
        logic [D_W-1:0] data;
    } ent_t;

    // Reference model state
    ent_t            mq [4][DEPTH];
    int              mcnt [4];
    int              rr [4];
    logic [WR_W-1:0] exp_wreq [4];
    logic [7:0]      exp_grant;
    logic            exp_conf;
    int              exp_perf [4];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WR_W-1:0] idle_req(input int k);
        logic [WR_W-1:0] r;
        r = '0;
        r[WR_W-1 -: 2] = 2'(k);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = 0;
            rr[i] = 0;
            exp_wreq[i] = idle_req(i);
            exp_perf[i] = 0;
        end
        exp_grant = '0;
        exp_conf = 1'b0;
    endtask

    task automatic check_outputs();
        chk("wreq0", 64'(W_request_0), 64'(exp_wreq[0]));
        chk("wreq1", 64'(W_request_1), 64'(exp_wreq[1]));
        chk("wreq2", 64'(W_request_2), 64'(exp_wreq[2]));
        chk("wreq3", 64'(W_request_3), 64'(exp_wreq[3]));
        chk("grant", 64'(bg_grant_lsu), 64'(exp_grant));
        chk("conflict", 64'(arb_conflict), 64'(exp_conf));
`ifdef BG_WARB_PERF_CNT_EN
        for (int i = 0; i < 4; i++)
            chk("perf", 64'(perf_blk_cnt[16*i +: 16]), 64'(exp_perf[i]));
`endif
    endtask

    // One clock cycle: drive the inputs, check ready, advance the model,
    // clock, and compare the registered outputs at the following negedge.
    task automatic step(input logic [3:0] v, input logic [7:0] s,
                        input logic [4*A_W-1:0] a, input logic [4*D_W-1:0] d,
                        input logic [3:0] ren);
        logic [3:0] exp_rdy;
        bit popped [4];
        bit found;
        int g, n, i;
        lsu_w_valid = v; lsu_w_sel = s; lsu_w_addr = a; lsu_w_data = d; bg_ren = ren;
        #1;
        for (int j = 0; j < 4; j++) begin
            exp_rdy[j] = (mcnt[j] < DEPTH);
            popped[j] = 0;
        end
        chk("ready", 64'(lsu_w_ready), 64'(exp_rdy));
        exp_conf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            for (int j = 0; j < 4; j++)
                if (mcnt[j] > 0 && int'(mq[j][0].sel) == k) n++;
            if (n >= 2 || (ren[k] && n > 0)) exp_conf = 1'b1;
            found = 0; g = 0;
            if (!ren[k]) begin
                for (int off = 0; off < 4; off++) begin
                    i = (rr[k] + off) % 4;
                    if (!found && mcnt[i] > 0 && int'(mq[i][0].sel) == k) begin
                        found = 1; g = i;
                    end
                end
            end
            if (found) begin
                exp_wreq[k] = {2'(k), 1'b1, mq[g][0].addr, mq[g][0].data};
                exp_grant[2*k +: 2] = 2'(g);
                rr[k] = (g + 1) % 4;
                popped[g] = 1;
            end else begin
                exp_wreq[k] = idle_req(k);
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (mcnt[j] > 0 && !popped[j] && exp_perf[j] < 65535) exp_perf[j]++;
            if (popped[j]) begin
                for (int m = 0; m < DEPTH - 1; m++) mq[j][m] = mq[j][m+1];
                mcnt[j]--;
            end
            if (v[j] && exp_rdy[j]) begin
                mq[j][mcnt[j]] = {s[2*j +: 2], a[A_W*j +: A_W], d[D_W*j +: D_W]};
                mcnt[j]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic [3:0] ren);
        step(4'h0, 8'h00, '0, '0, ren);
    endtask

    initial begin
        logic [4*A_W-1:0] ra;
        logic [4*D_W-1:0] rd;
        logic [3:0]       rren;

        // Reset state
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(lsu_w_ready), 64'hF);
        check_outputs();
        rst_n = 1'b1;

        // Single write: LSU2 -> BG1
        ra = '0; rd = '0;
        ra[2*A_W +: A_W] = 10'h005;
        rd[2*D_W +: D_W] = 32'hDEADBEEF;
        step(4'b0100, 8'h10, ra, rd, 4'h0);
        idle(4'h0);
        chk("single_slot1", 64'(W_request_1), 64'({2'd1, 1'b1, 10'h005, 32'hDEADBEEF}));
        chk("single_grant", 64'(bg_grant_lsu[3:2]), 64'd2);
        idle(4'h0);

        // Full contention on BG3
        for (int i = 0; i < 4; i++) begin
            ra[A_W*i +: A_W] = A_W'(16 + i);
            rd[D_W*i +: D_W] = 32'hC0DE0000 + 32'(i);
        end
        step(4'hF, 8'hFF, ra, rd, 4'h0);
        for (int c = 0; c < 4; c++) begin
            idle(4'h0);
            chk("contend_order", 64'(bg_grant_lsu[7:6]), 64'(c));
        end
        idle(4'h0);

        // Read block on BG0 for three cycles
        ra[A_W-1:0] = 10'h0AA; rd[D_W-1:0] = 32'h12345678;
        step(4'b0001, 8'h00, ra, rd, 4'h0);
        idle(4'h1); idle(4'h1); idle(4'h1);
        idle(4'h0);
        chk("rdblk_issue", 64'(W_request_0), 64'({2'd0, 1'b1, 10'h0AA, 32'h12345678}));
        idle(4'h0);

        // Backpressure: LSU1 -> BG2 while BG2 is read-blocked
        for (int c = 0; c < 4; c++) begin
            ra[A_W +: A_W] = A_W'(32 + c);
            rd[D_W +: D_W] = 32'hBB000000 + 32'(c);
            step(4'b0010, 8'h08, ra, rd, 4'h4);
        end
        for (int c = 0; c < 4; c++) idle(4'h0);

        // Parallel issue: LSU i -> BG 3-i
        for (int i = 0; i < 4; i++) rd[D_W*i +: D_W] = 32'hA0A00000 + 32'(i);
        step(4'hF, 8'h1B, ra, rd, 4'h0);
        idle(4'h0);
        chk("parallel_wen", 64'({W_request_0[WR_W-3], W_request_1[WR_W-3],
                                 W_request_2[WR_W-3], W_request_3[WR_W-3]}), 64'hF);
        idle(4'h0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                ra[A_W*i +: A_W] = A_W'($urandom);
                rd[D_W*i +: D_W] = $urandom;
                rren[i] = ($urandom_range(0, 3) == 0);
            end
            step(4'($urandom), 8'($urandom), ra, rd, rren);
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 4; i++) rd[D_W*i +: D_W] = $urandom;
        step(4'hF, 8'h55, ra, rd, 4'h0);
        step(4'hF, 8'h00, ra, rd, 4'h0);
        lsu_w_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_ready", 64'(lsu_w_ready), 64'hF);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) idle(4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
